// File: rtl/pll_drp_seq_if.sv
// DRP bus between the reconfiguration sequencer and the PLL_ADV primitive.
// DCLK is the sequencer clock and is wired outside this interface.
interface pll_drp_seq_if;
    logic [4:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DEN;
    logic        DWE;
    logic        DRDY;

    modport master (output DADDR, DI, DEN, DWE, input DO, DRDY);
    modport slave  (input DADDR, DI, DEN, DWE, output DO, DRDY);
endinterface

// File: rtl/pll_drp_seq.sv
// PLL_ADV DRP read-modify-write sequencer: holds the PLL in reset, merges NREG
// table entries into the DRP registers, then releases reset and waits for lock.
module pll_drp_seq #(
    parameter int SEL_W   = 4,
    parameter int NREG    = 23,
    parameter int IDX_W   = 5,
    parameter int DRDY_TO = 64,
    parameter int LOCK_TO = 65535
) (
    input  logic                   CLK,
    input  logic                   RSTX,
    input  logic [SEL_W-1:0]       SEL,
    input  logic                   START,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR,
    output logic [SEL_W+IDX_W-1:0] ROM_ADDR,
    input  logic [36:0]            ROM_DATA,
    pll_drp_seq_if.master          drp,
    output logic                   RST_PLL,
    input  logic                   LOCKED
);
    localparam int TMAX = (DRDY_TO > LOCK_TO) ? DRDY_TO : LOCK_TO;
    localparam int TW   = $clog2(TMAX + 1);

    typedef logic [TW-1:0] tmr_t;
    localparam tmr_t             DRDY_LAST = tmr_t'(DRDY_TO - 1);
    localparam tmr_t             LOCK_LAST = tmr_t'(LOCK_TO - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREG - 1);

    typedef enum logic [2:0] {
        IDLE, ROMWAIT, RD, RDWAIT, WR, WRWAIT, NEXT, LOCKWAIT
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              den_q, den_d;
    logic              dwe_q, dwe_d;
    logic              rst_pll_q, rst_pll_d;
    logic [4:0]        daddr_q, daddr_d;
    logic [15:0]       di_q, di_d;
    logic [15:0]       mask_q, mask_d;
    logic [15:0]       data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    tmr_t              tmr_q, tmr_d;
    logic              fail;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            rst_pll_q <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            rst_pll_q <= rst_pll_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        den_d     = 1'b0;
        dwe_d     = 1'b0;
        rst_pll_d = rst_pll_q;
        daddr_d   = daddr_q;
        di_d      = di_q;
        mask_d    = mask_q;
        data_d    = data_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        fail      = 1'b0;

        case (state_q)
            IDLE: begin
                // The DONE cycle is still IDLE, but a START there is dropped.
                if (START && !done_q) begin
                    state_d   = ROMWAIT;
                    busy_d    = 1'b1;
                    rst_pll_d = 1'b1;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    sel_d     = SEL;
                end
            end
            ROMWAIT: state_d = RD;
            RD: begin
                den_d   = 1'b1;
                daddr_d = ROM_DATA[36:32];
                mask_d  = ROM_DATA[31:16];
                data_d  = ROM_DATA[15:0];
                state_d = RDWAIT;
            end
            RDWAIT: begin
                if (drp.DRDY) begin
                    // Mask bit set keeps the bit the PLL already holds.
                    di_d    = (drp.DO & mask_q) | (data_q & ~mask_q);
                    state_d = WR;
                end else if (tmr_q == DRDY_LAST) begin
                    fail = 1'b1;
                end
            end
            WR: begin
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                state_d = WRWAIT;
            end
            WRWAIT: begin
                if (drp.DRDY)                  state_d = NEXT;
                else if (tmr_q == DRDY_LAST)   fail    = 1'b1;
            end
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    rst_pll_d = 1'b0;
                    state_d   = LOCKWAIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ROMWAIT;
                end
            end
            LOCKWAIT: begin
                if (LOCKED) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmr_q == LOCK_LAST) begin
                    fail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            err_d     = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            rst_pll_d = 1'b0;
            den_d     = 1'b0;
            dwe_d     = 1'b0;
            state_d   = IDLE;
        end

        // Timer restarts on every state entry and saturates at all-ones.
        if (state_d != state_q)  tmr_d = '0;
        else if (&tmr_q)         tmr_d = tmr_q;
        else                     tmr_d = tmr_q + 1'b1;
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign RST_PLL   = rst_pll_q;
    assign ROM_ADDR  = {sel_q, idx_q};
    assign drp.DADDR = daddr_q;
    assign drp.DI    = di_q;
    assign drp.DEN   = den_q;
    assign drp.DWE   = dwe_q;
endmodule
